// File: rtl/pad_seq_pkg.sv
// Pad control sequencer: shared state and step-table types.
// Step fields are sized for the widest supported configuration.
package pad_seq_pkg;

    localparam int MAX_CTRL  = 32;
    localparam int MAX_DWELL = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [MAX_CTRL-1:0]  mask;
        logic                 pump_en;
        logic [MAX_DWELL-1:0] dwell;
    } step_t;

    function automatic step_t make_step(
        input logic [MAX_CTRL-1:0]  mask,
        input logic                 pump_en,
        input logic [MAX_DWELL-1:0] dwell
    );
        step_t s;
        s.mask    = mask;
        s.pump_en = pump_en;
        s.dwell   = dwell;
        return s;
    endfunction

endpackage

// File: rtl/pad_ctrl_sequencer_pump.sv
// Peristaltic pump phase rotation: one vented valve walks around the ring.
// Phase and prescaler hold their count while enabled and clear when not.
module pump_phase_gen #(
    parameter int N_PUMP   = 3,
    parameter int PUMP_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    output logic [N_PUMP-1:0] pump_pad
);

    localparam int PW = $clog2(N_PUMP);
    localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(N_PUMP - 1);
    localparam logic [DW-1:0] PRE_LAST = DW'(PUMP_DIV - 1);

    logic [PW-1:0] phase_q;
    logic [DW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            pre_q   <= '0;
        end else if (!en) begin
            phase_q <= '0;
            pre_q   <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + DW'(1);
            if (tick) begin
                if (dir)
                    phase_q <= (phase_q == '0) ? PH_LAST : phase_q - PW'(1);
                else
                    phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
            end
        end
    end

    always_comb begin
        pump_pad          = '1;
        pump_pad[phase_q] = 1'b0;
    end

endmodule

// File: rtl/pad_ctrl_sequencer.sv
// Microfluidic valve pad sequencer: steps a programmed mask table,
// drives the pump ring, then vents everything for a fixed flush.
module pad_ctrl_sequencer
    import pad_seq_pkg::*;
#(
    parameter int N_CTRL    = 11,
    parameter int N_PUMP    = 3,
    parameter int STEPS     = 16,
    parameter int TIMER_W   = 16,
    parameter int PUMP_DIV  = 8,
    parameter int FLUSH_CYC = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(STEPS):0]     prog_len,
    input  logic                       pump_dir,
    input  logic                       wr_en,
    input  logic [$clog2(STEPS)-1:0]   wr_addr,
    input  logic [N_CTRL-1:0]          wr_mask,
    input  logic                       wr_pump_en,
    input  logic [TIMER_W-1:0]         wr_dwell,
    output logic [N_CTRL-1:0]          ctrl_pad,
    output logic [N_PUMP-1:0]          pump_pad,
    output logic                       flush_active,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(STEPS)-1:0]   cur_step,
    output logic                       wr_err
);

    localparam int AW = $clog2(STEPS);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int CW = (TIMER_W > FW) ? TIMER_W : FW;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [LW-1:0] LEN_MAX    = LW'(STEPS);

    seq_state_t state, state_n;

    logic [N_CTRL-1:0]  mask_mem  [STEPS];
    logic               pen_mem   [STEPS];
    logic [TIMER_W-1:0] dwell_mem [STEPS];

    logic [AW-1:0] step_q;
    logic [LW-1:0] len_q;
    logic [CW-1:0] cnt_q;

    step_t              cur;
    logic [TIMER_W-1:0] dwell_v;
    logic [CW-1:0]      dwell_last;
    logic [LW-1:0]      len_in;
    logic               step_exp;
    logic               last_step;
    logic               flush_exp;
    logic               addr_bad;
    logic               pump_en;
    logic [N_PUMP-1:0]  gen_pad;
    logic               unused_hi;

    logic [N_CTRL-1:0] ctrl_d;
    logic [N_PUMP-1:0] pump_d;
    logic              flush_d;
    logic              busy_d;
    logic              done_d;
    logic [AW-1:0]     step_d;

    assign cur = make_step(MAX_CTRL'(mask_mem[step_q]), pen_mem[step_q],
                           MAX_DWELL'(dwell_mem[step_q]));
    assign unused_hi  = ^cur;
    assign dwell_v    = cur.dwell[TIMER_W-1:0];
    assign dwell_last = (dwell_v == '0) ? '0 : CW'(dwell_v) - CW'(1);
    assign step_exp   = (cnt_q == dwell_last);
    assign last_step  = (({1'b0, step_q} + LW'(1)) == len_q);
    assign flush_exp  = (cnt_q == FLUSH_LAST);
    assign len_in     = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign addr_bad   = (32'(wr_addr) >= STEPS);
    assign pump_en    = (state == S_RUN) && cur.pump_en;

    // Table is plain storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en && (state == S_IDLE) && !addr_bad) begin
            mask_mem[wr_addr]  <= wr_mask;
            pen_mem[wr_addr]   <= wr_pump_en;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = (len_in == '0) ? S_FLUSH : S_RUN;
            S_RUN:   if (abort || (step_exp && last_step)) state_n = S_FLUSH;
            S_FLUSH: if (flush_exp) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    step_q <= '0;
                    cnt_q  <= '0;
                    if (start) len_q <= len_in;
                end
                S_RUN: begin
                    if (abort || step_exp) begin
                        cnt_q <= '0;
                        if (!abort && !last_step) step_q <= step_q + AW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FLUSH: cnt_q <= flush_exp ? '0 : cnt_q + CW'(1);
                S_DONE:  cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

    pump_phase_gen #(
        .N_PUMP   (N_PUMP),
        .PUMP_DIV (PUMP_DIV)
    ) u_pump (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pump_en),
        .dir      (pump_dir),
        .pump_pad (gen_pad)
    );

    always_comb begin
        ctrl_d  = '0;
        pump_d  = '0;
        flush_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        step_d  = '0;
        unique case (state)
            S_RUN: begin
                ctrl_d = cur.mask[N_CTRL-1:0];
                pump_d = cur.pump_en ? gen_pad : '1;
                busy_d = 1'b1;
                step_d = step_q;
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_pad     <= '0;
            pump_pad     <= '0;
            flush_active <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_step     <= '0;
            wr_err       <= 1'b0;
        end else begin
            ctrl_pad     <= ctrl_d;
            pump_pad     <= pump_d;
            flush_active <= flush_d;
            busy         <= busy_d;
            done         <= done_d;
            cur_step     <= step_d;
            wr_err       <= wr_en && ((state != S_IDLE) || addr_bad);
        end
    end

endmodule

// File: doc/pad_ctrl_sequencer.md
PAD_CTRL_SEQUENCER -- requirements
Module: pad_ctrl_sequencer

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter N_CTRL, default 11, number of valve control pads.
REQ-003 SHALL have parameter N_PUMP, default 3, number of peristaltic pump valve pads (>=3).
REQ-004 SHALL have parameter STEPS, default 16, step-table depth.
REQ-005 SHALL have parameter TIMER_W, default 16, dwell counter width.
REQ-006 SHALL have parameter PUMP_DIV, default 8, cycles per pump phase (>=1).
REQ-007 SHALL have parameter FLUSH_CYC, default 32, flush duration in cycles (>=1).
REQ-008 SHALL have port clk, input, 1, system clock.
REQ-009 SHALL have port rst_n, input, 1, async active-low reset.
REQ-010 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-011 SHALL have port abort, input, 1, terminate run and flush.
REQ-012 SHALL have port prog_len, input, $clog2(STEPS)+1, number of steps to execute.
REQ-013 SHALL have port pump_dir, input, 1, pump phase order (0 ascending, 1 descending).
REQ-014 SHALL have ports wr_en (input, 1), wr_addr (input, $clog2(STEPS)), wr_mask (input, N_CTRL), wr_pump_en (input, 1) and wr_dwell (input, TIMER_W), all of which form the step-table write port.
REQ-015 SHALL have port ctrl_pad, output, N_CTRL, valve pressure (1 = pressurised/closed).
REQ-016 SHALL have port pump_pad, output, N_PUMP, pump valve pressure.
REQ-017 SHALL have ports flush_active, busy and done (output, 1 each), which indicate flush phase, not-IDLE, and a one-cycle completion pulse respectively.
REQ-018 SHALL have ports cur_step (output, $clog2(STEPS)), executing step index, and wr_err (output, 1), one-cycle pulse on a rejected write.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH and DONE.
REQ-020 SHALL, in IDLE, enter RUN at cur_step=0 when start=1 and prog_len>0; when start=1 and prog_len=0, SHALL enter FLUSH directly.
REQ-021 SHALL register all outputs; with start sampled at edge t, ctrl_pad SHALL equal mask[0] after edge t+1.
REQ-022 SHALL hold each step for max(dwell,1) cycles, then advance cur_step; after step prog_len-1 expires, SHALL enter FLUSH.
REQ-023 SHALL give abort priority over step expiry in RUN, entering FLUSH on the next edge; abort SHALL be ignored in FLUSH, DONE and IDLE.
REQ-024 SHALL, in FLUSH, drive ctrl_pad=0 and pump_pad=0 and assert flush_active for exactly FLUSH_CYC cycles, then enter DONE.
REQ-025 SHALL, in DONE, pulse done for one cycle and then return to IDLE.
REQ-026 SHALL, in RUN with the step's pump_en=1, drive pump_pad to all ones except bit phase=0; phase SHALL advance every PUMP_DIV cycles, wrapping N_PUMP-1 to 0 (ascending) or 0 to N_PUMP-1 (descending).
REQ-027 SHALL, in RUN with pump_en=0, drive pump_pad to all ones, clear phase to 0 and clear the prescaler.
REQ-028 SHALL preserve phase and prescaler across consecutive steps that both have pump_en=1.
REQ-029 SHALL accept table writes in IDLE only; a write while busy SHALL be dropped and wr_err SHALL pulse one cycle.
REQ-030 SHALL treat wr_addr>=STEPS and prog_len>STEPS as errors: the write SHALL be dropped with a wr_err pulse, and prog_len SHALL be clamped to STEPS.
REQ-031 SHALL, in IDLE, drive ctrl_pad=0, pump_pad=0, busy=0 and cur_step=0.

Reset
REQ-032 SHALL, on rst_n low, immediately enter IDLE with every output 0, the phase, prescaler and dwell counters at 0, and no done pulse.
REQ-033 SHALL leave step-table contents undefined after reset and SHALL NOT require the table to be reset.
REQ-034 SHALL, when reset is asserted mid-RUN or mid-FLUSH, abandon the operation without entering FLUSH.

Structure
REQ-035 SHALL place the state enum and the step-entry struct {mask, pump_en, dwell} in shared package pad_seq_pkg.
REQ-036 SHALL implement the pump phase rotation and prescaler in sub-module pump_phase_gen (parameters N_PUMP and PUMP_DIV; ports clk, rst_n, en, dir, pump_pad).

Verification
REQ-037 SHALL cover this scenario: program steps 0..1 as {mask=11'h001,dwell=3} and {mask=11'h400,dwell=0}, prog_len=2, then start; ctrl_pad SHALL be 001 for 3 cycles, then 400 for 1 cycle, then 0 with flush_active for 32 cycles, then done for 1 cycle.
REQ-038 SHALL cover this scenario: one step with pump_en=1, dwell=48, pump_dir=0; pump_pad SHALL cycle 110, 101, 011 in 8-cycle phases, then repeat.
REQ-039 SHALL cover this scenario: same as REQ-038 with pump_dir=1; pump_pad SHALL cycle 110, 011, 101.
REQ-040 SHALL cover this scenario: abort asserted in the 2nd cycle of a 10-cycle step; FLUSH SHALL be entered next edge and done SHALL pulse 33 cycles later.
REQ-041 SHALL cover this scenario: wr_en during RUN; wr_err SHALL pulse and a later readback run SHALL show the table entry unchanged.
REQ-042 SHALL cover this scenario: rst_n dropped mid-FLUSH; all outputs SHALL be 0 asynchronously, and no done pulse SHALL follow reset release.
